// File: rtl/tt_rts_rtr_pkg.sv
// Shared constants and width helpers for the RTS/RTR elastic buffer family.
package tt_rts_rtr_pkg;

    localparam int unsigned RTR_MODE_PASS = 0;
    localparam int unsigned RTR_MODE_REG  = 1;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width; a single-entry buffer still carries a 1-bit pointer.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tt_rts_rtr_fifo_ptr.sv
// Read/write pointer and occupancy controller for the elastic buffer.
module tt_rts_rtr_fifo_ptr
    import tt_rts_rtr_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PW    = ptr_w(DEPTH),
    localparam int unsigned CW    = cnt_w(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [PW-1:0] o_wr_ptr,
    output logic [PW-1:0] o_rd_ptr,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q;

    // Wrap by explicit compare so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (i_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (i_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            unique case ({i_push, i_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    assign o_wr_ptr = wr_ptr_q;
    assign o_rd_ptr = rd_ptr_q;
    assign o_count  = count_q;
    assign o_full   = full_q;
    assign o_empty  = empty_q;

endmodule

// File: rtl/tt_rts_rtr_elastic_fifo.sv
// DEPTH-entry elastic buffer on an RTS/RTR channel with flush and selectable
// pass-through or registered upstream ready.
module tt_rts_rtr_elastic_fifo
    import tt_rts_rtr_pkg::*;
#(
    parameter  int unsigned WIDTH         = 1,
    parameter  int unsigned DEPTH         = 2,
    parameter  int unsigned RTR_MODE      = RTR_MODE_PASS,
    parameter  int unsigned NORTS_DROPPED = 0,
    localparam int unsigned PW            = ptr_w(DEPTH),
    localparam int unsigned CW            = cnt_w(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_flush,
    input  logic             i_rts,
    output logic             o_rtr,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_rts,
    input  logic             i_rtr,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic             push;
    logic             pop;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign push  = i_rts && o_rtr;
    assign pop   = o_rts && i_rtr;
    assign o_rts = !o_empty;

    // Registered mode trades half throughput at DEPTH=1 for no i_rtr->o_rtr path.
    if (RTR_MODE == RTR_MODE_REG) begin : g_rtr_reg
        assign o_rtr = !i_flush && !o_full;
    end else begin : g_rtr_pass
        assign o_rtr = !i_flush && (!o_full || i_rtr);
    end

    tt_rts_rtr_fifo_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (push),
        .i_pop     (pop),
        .i_flush   (i_flush),
        .o_wr_ptr  (wr_ptr),
        .o_rd_ptr  (rd_ptr),
        .o_count   (o_count),
        .o_full    (o_full),
        .o_empty   (o_empty)
    );

    // Storage is cleared on reset so o_data reads zero out of reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_ptr == PW'(i)) mem[i] <= i_data;
            end
        end
    end

    always_comb begin
        o_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rd_ptr == PW'(i)) o_data = mem[i];
        end
    end

`ifdef SIM
    logic             pend_q;
    logic [WIDTH-1:0] pend_data_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pend_q      <= 1'b0;
            pend_data_q <= '0;
        end else begin
            pend_q      <= i_rts && !o_rtr;
            pend_data_q <= i_data;
        end
    end

    always @(posedge i_clk) begin
        if (i_reset_n) begin
            if (pend_q && i_rts) assert (i_data == pend_data_q)
                else $error("data changed while request pending");
            assert (!(push && o_full && !pop)) else $error("push into full buffer");
            assert (!(pop && o_empty)) else $error("pop from empty buffer");
        end
    end
`endif

    if (NORTS_DROPPED == 0) begin : g_rts_drop_chk
`ifdef SIM
        always @(posedge i_clk) begin
            if (i_reset_n && pend_q) assert (i_rts) else $error("rts dropped without rtr");
        end
`endif
    end

endmodule

// File: tb/tb_tt_rts_rtr_elastic_fifo.sv
// Directed bench for tt_rts_rtr_elastic_fifo across several depth/mode builds.
module tb_tt_rts_rtr_elastic_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    // A: DEPTH=4 mode 0
    logic a_flush, a_rts, a_o_rtr, a_rtr, a_o_rts, a_full, a_empty;
    logic [7:0] a_data, a_o_data;
    logic [2:0] a_count;
    // B: DEPTH=3 mode 1
    logic b_flush, b_rts, b_o_rtr, b_rtr, b_o_rts, b_full, b_empty;
    logic [7:0] b_data, b_o_data;
    logic [1:0] b_count;
    // C: DEPTH=2 mode 0
    logic c_flush, c_rts, c_o_rtr, c_rtr, c_o_rts, c_full, c_empty;
    logic [7:0] c_data, c_o_data;
    logic [1:0] c_count;
    // D: DEPTH=5 mode 1
    logic d_flush, d_rts, d_o_rtr, d_rtr, d_o_rts, d_full, d_empty;
    logic [7:0] d_data, d_o_data;
    logic [2:0] d_count;
    // E: DEPTH=1 mode 0
    logic e_flush, e_rts, e_o_rtr, e_rtr, e_o_rts, e_full, e_empty;
    logic [7:0] e_data, e_o_data;
    logic [0:0] e_count;

    tt_rts_rtr_elastic_fifo #(.WIDTH(8), .DEPTH(4), .RTR_MODE(0), .NORTS_DROPPED(0)) u_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_flush(a_flush), .i_rts(a_rts), .o_rtr(a_o_rtr),
        .i_data(a_data), .o_rts(a_o_rts), .i_rtr(a_rtr), .o_data(a_o_data),
        .o_count(a_count), .o_full(a_full), .o_empty(a_empty));
    tt_rts_rtr_elastic_fifo #(.WIDTH(8), .DEPTH(3), .RTR_MODE(1), .NORTS_DROPPED(0)) u_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_flush(b_flush), .i_rts(b_rts), .o_rtr(b_o_rtr),
        .i_data(b_data), .o_rts(b_o_rts), .i_rtr(b_rtr), .o_data(b_o_data),
        .o_count(b_count), .o_full(b_full), .o_empty(b_empty));
    tt_rts_rtr_elastic_fifo #(.WIDTH(8), .DEPTH(2), .RTR_MODE(0), .NORTS_DROPPED(0)) u_c (
        .i_clk(clk), .i_reset_n(rst_n), .i_flush(c_flush), .i_rts(c_rts), .o_rtr(c_o_rtr),
        .i_data(c_data), .o_rts(c_o_rts), .i_rtr(c_rtr), .o_data(c_o_data),
        .o_count(c_count), .o_full(c_full), .o_empty(c_empty));
    tt_rts_rtr_elastic_fifo #(.WIDTH(8), .DEPTH(5), .RTR_MODE(1), .NORTS_DROPPED(0)) u_d (
        .i_clk(clk), .i_reset_n(rst_n), .i_flush(d_flush), .i_rts(d_rts), .o_rtr(d_o_rtr),
        .i_data(d_data), .o_rts(d_o_rts), .i_rtr(d_rtr), .o_data(d_o_data),
        .o_count(d_count), .o_full(d_full), .o_empty(d_empty));
    tt_rts_rtr_elastic_fifo #(.WIDTH(8), .DEPTH(1), .RTR_MODE(0), .NORTS_DROPPED(0)) u_e (
        .i_clk(clk), .i_reset_n(rst_n), .i_flush(e_flush), .i_rts(e_rts), .o_rtr(e_o_rtr),
        .i_data(e_data), .o_rts(e_o_rts), .i_rtr(e_rtr), .o_data(e_o_data),
        .o_count(e_count), .o_full(e_full), .o_empty(e_empty));

    task automatic test_reset();
        @(negedge clk);
        total_cnt++; if (a_o_rts !== 1'b0) $display("FAIL reset_rts got %b want 0", a_o_rts); else pass_cnt++;
        total_cnt++; if (a_count !== 3'd0) $display("FAIL reset_count got %0d want 0", a_count); else pass_cnt++;
        total_cnt++; if (a_empty !== 1'b1 || a_full !== 1'b0) $display("FAIL reset_flags got e%b f%b want e1 f0", a_empty, a_full); else pass_cnt++;
        total_cnt++; if (a_o_rtr !== 1'b1) $display("FAIL reset_rtr got %b want 1", a_o_rtr); else pass_cnt++;
        total_cnt++; if (a_o_data !== 8'h00) $display("FAIL reset_data got %h want 00", a_o_data); else pass_cnt++;
        @(posedge clk); #1;
        // hold three entries, then assert reset between edges
        a_rtr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_rts = 1'b1; a_data = 8'(8'h11 * (i + 1));
            @(posedge clk); #1;
        end
        a_rts = 1'b0;
        @(negedge clk);
        total_cnt++; if (a_count !== 3'd3) $display("FAIL pre_reset_count got %0d want 3", a_count); else pass_cnt++;
        total_cnt++; if (a_o_data !== 8'h11) $display("FAIL pre_reset_data got %h want 11", a_o_data); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (a_o_rts !== 1'b0) $display("FAIL midreset_rts got %b want 0", a_o_rts); else pass_cnt++;
        total_cnt++; if (a_count !== 3'd0) $display("FAIL midreset_count got %0d want 0", a_count); else pass_cnt++;
        total_cnt++; if (a_o_data !== 8'h00) $display("FAIL midreset_data got %h want 00", a_o_data); else pass_cnt++;
        total_cnt++; if (a_o_rtr !== 1'b1) $display("FAIL midreset_rtr got %b want 1", a_o_rtr); else pass_cnt++;
        total_cnt++; if (a_empty !== 1'b1 || a_full !== 1'b0) $display("FAIL midreset_flags got e%b f%b want e1 f0", a_empty, a_full); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [3];
        vals[0] = 8'h0A; vals[1] = 8'h0B; vals[2] = 8'h0C;
        b_rtr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b_rts = 1'b1; b_data = vals[i];
            @(negedge clk);
            total_cnt++; if (b_o_rtr !== 1'b1) $display("FAIL fill_rtr%0d got %b want 1", i, b_o_rtr); else pass_cnt++;
            @(posedge clk); #1;
        end
        b_rts = 1'b0;
        @(negedge clk);
        total_cnt++; if (b_full !== 1'b1) $display("FAIL fill_full got %b want 1", b_full); else pass_cnt++;
        total_cnt++; if (b_o_rtr !== 1'b0) $display("FAIL fill_rtr_full got %b want 0", b_o_rtr); else pass_cnt++;
        total_cnt++; if (b_count !== 2'd3) $display("FAIL fill_count got %0d want 3", b_count); else pass_cnt++;
        @(posedge clk); #1;
        b_rtr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++; if (b_o_rts !== 1'b1) $display("FAIL drain_rts%0d got %b want 1", i, b_o_rts); else pass_cnt++;
            total_cnt++; if (b_o_data !== vals[i]) $display("FAIL drain_data%0d got %h want %h", i, b_o_data, vals[i]); else pass_cnt++;
            if (i == 0) begin
                total_cnt++; if (b_o_rtr !== 1'b0) $display("FAIL reg_rtr_full got %b want 0", b_o_rtr); else pass_cnt++;
            end
            @(posedge clk); #1;
        end
        b_rtr = 1'b0;
        @(negedge clk);
        total_cnt++; if (b_empty !== 1'b1 || b_o_rts !== 1'b0) $display("FAIL drain_empty got e%b rts%b want e1 rts0", b_empty, b_o_rts); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_full_pass();
        c_rtr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            c_rts = 1'b1; c_data = 8'(8'h40 + i);
            @(posedge clk); #1;
        end
        c_rtr = 1'b1;
        for (int k = 0; k < 10; k++) begin
            c_data = 8'(8'h42 + k);
            @(negedge clk);
            total_cnt++; if (c_o_rtr !== 1'b1) $display("FAIL pass_rtr%0d got %b want 1", k, c_o_rtr); else pass_cnt++;
            total_cnt++; if (c_count !== 2'd2) $display("FAIL pass_count%0d got %0d want 2", k, c_count); else pass_cnt++;
            total_cnt++; if (c_o_data !== 8'(8'h40 + k)) $display("FAIL pass_data%0d got %h want %h", k, c_o_data, 8'(8'h40 + k)); else pass_cnt++;
            @(posedge clk); #1;
        end
        c_rts = 1'b0;
        for (int k = 10; k < 12; k++) begin
            @(negedge clk);
            total_cnt++; if (c_o_data !== 8'(8'h40 + k)) $display("FAIL pass_tail%0d got %h want %h", k, c_o_data, 8'(8'h40 + k)); else pass_cnt++;
            @(posedge clk); #1;
        end
        c_rtr = 1'b0;
        @(negedge clk);
        total_cnt++; if (c_empty !== 1'b1) $display("FAIL pass_empty got %b want 1", c_empty); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        int sent = 0;
        int recv = 0;
        int cyc = 0;
        logic exp_rtr, push, pop;
        d_rts = 1'b1; d_data = 8'h80;
        d_rtr = ($urandom_range(0, 2) == 0);
        while (recv < 20 && cyc < 400) begin
            @(negedge clk);
            exp_rtr = (q.size() < 5);
            push = d_rts && exp_rtr;
            pop = (q.size() != 0) && d_rtr;
            total_cnt++; if (d_o_rtr !== exp_rtr) $display("FAIL wrap_rtr c%0d got %b want %b", cyc, d_o_rtr, exp_rtr); else pass_cnt++;
            total_cnt++; if (d_count !== 3'(q.size()) || d_count > 3'd5) $display("FAIL wrap_count c%0d got %0d want %0d", cyc, d_count, q.size()); else pass_cnt++;
            if (pop) begin
                total_cnt++; if (d_o_data !== q[0]) $display("FAIL wrap_data c%0d got %h want %h", cyc, d_o_data, q[0]); else pass_cnt++;
            end
            @(posedge clk);
            if (pop) begin void'(q.pop_front()); recv++; end
            if (push) begin q.push_back(d_data); sent++; end
            #1;
            if (push) begin
                if (sent < 20) d_data = 8'(8'h80 + sent);
                else d_rts = 1'b0;
            end
            d_rtr = ($urandom_range(0, 2) == 0);
            cyc++;
        end
        total_cnt++; if (recv != 20) $display("FAIL wrap_received got %0d want 20", recv); else pass_cnt++;
        d_rtr = 1'b0; d_rts = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        a_rtr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_rts = 1'b1; a_data = 8'(8'h51 + i);
            @(posedge clk); #1;
        end
        a_flush = 1'b1; a_rtr = 1'b1; a_rts = 1'b1; a_data = 8'h54;
        @(negedge clk);
        total_cnt++; if (a_o_rtr !== 1'b0) $display("FAIL flush_rtr got %b want 0", a_o_rtr); else pass_cnt++;
        total_cnt++; if (a_o_rts !== 1'b1 || a_o_data !== 8'h51) $display("FAIL flush_head got rts%b %h want rts1 51", a_o_rts, a_o_data); else pass_cnt++;
        @(posedge clk); #1;
        a_flush = 1'b0; a_rtr = 1'b0;
        @(negedge clk);
        total_cnt++; if (a_count !== 3'd0 || a_empty !== 1'b1) $display("FAIL flush_count got %0d e%b want 0 e1", a_count, a_empty); else pass_cnt++;
        total_cnt++; if (a_o_rts !== 1'b0 || a_o_rtr !== 1'b1) $display("FAIL flush_after got rts%b rtr%b want rts0 rtr1", a_o_rts, a_o_rtr); else pass_cnt++;
        @(posedge clk); #1;
        a_rts = 1'b0;
        @(negedge clk);
        total_cnt++; if (a_count !== 3'd1 || a_o_data !== 8'h54) $display("FAIL flush_retry got %0d %h want 1 54", a_count, a_o_data); else pass_cnt++;
        @(posedge clk); #1;
        a_rtr = 1'b1;
        @(posedge clk); #1;
        a_rtr = 1'b0;
        @(negedge clk);
        total_cnt++; if (a_empty !== 1'b1) $display("FAIL flush_drain got %b want 1", a_empty); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_legacy();
        logic lv = 1'b0;
        logic [7:0] ld = 8'h00;
        logic exp_rtr, push;
        e_rts = 1'b0; e_rtr = 1'b0; e_data = 8'h00;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            exp_rtr = !lv || e_rtr;
            push = e_rts && exp_rtr;
            total_cnt++; if (e_o_rts !== lv) $display("FAIL legacy_rts c%0d got %b want %b", cyc, e_o_rts, lv); else pass_cnt++;
            total_cnt++; if (e_o_rtr !== exp_rtr) $display("FAIL legacy_rtr c%0d got %b want %b", cyc, e_o_rtr, exp_rtr); else pass_cnt++;
            total_cnt++; if (e_o_data !== ld) $display("FAIL legacy_data c%0d got %h want %h", cyc, e_o_data, ld); else pass_cnt++;
            @(posedge clk);
            if (push) begin lv = 1'b1; ld = e_data; end
            else if (e_rtr) lv = 1'b0;
            #1;
            if (!e_rts || push) begin
                e_rts = 1'($urandom_range(0, 1));
                e_data = 8'($urandom_range(0, 255));
            end
            e_rtr = 1'($urandom_range(0, 1));
        end
        e_rts = 1'b0; e_rtr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        {a_flush, a_rts, a_rtr, a_data} = '0;
        {b_flush, b_rts, b_rtr, b_data} = '0;
        {c_flush, c_rts, c_rtr, c_data} = '0;
        {d_flush, d_rts, d_rtr, d_data} = '0;
        {e_flush, e_rts, e_rtr, e_data} = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_fill_drain();
        test_full_pass();
        test_wrap();
        test_flush();
        test_legacy();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tt_rts_rtr_elastic_fifo.md
# tt_rts_rtr_elastic_fifo

Parametrised successor to the single-entry RTS/RTR pipe stage: a DEPTH-entry elastic buffer on an RTS/RTR (valid/ready) channel. It provides full-throughput streaming, an occupancy count, a synchronous flush and a selectable ready mode. The selectable mode breaks the combinational i_rtr→o_rtr path for timing closure. It drops into VPU datapaths wherever a pipe stage sits and more slack or decoupling is needed.

## Interface
- WIDTH, 1: payload width in bits.
- DEPTH, 2: number of entries; legal values are ≥1, and non-power-of-two values are allowed.
- RTR_MODE, 0:
  - 0 = pass-through ready: when full, o_rtr follows i_rtr.
  - 1 = registered ready: o_rtr depends only on state and i_flush, never on i_rtr.
- NORTS_DROPPED, 0: 1 disables the simulation check "RTS dropped without RTR".
- i_clk  in  1  sole clock; all state updates on posedge.
- i_reset_n  in  1  reset, asynchronous assert, active-low.
- i_flush  in  1  synchronous discard of all entries.
- i_rts  in  1  upstream request.
- o_rtr  out  1  ready to upstream.
- i_data  in  WIDTH  upstream payload.
- o_rts  out  1  downstream request.
- i_rtr  in  1  downstream ready.
- o_data  out  WIDTH  head-entry payload.
- o_count  out  CW = $clog2(DEPTH+1)  number of occupied entries.
- o_full / o_empty  out  1  count==DEPTH / count==0.

## Operation
- push = i_rts & o_rtr; pop = o_rts & i_rtr.
- o_rts = !o_empty; o_data = mem[rd_ptr]. No bypass: an empty FIFO never presents in the same cycle.
- o_rtr:
  - RTR_MODE 0: !i_flush & (!full | i_rtr).
  - RTR_MODE 1: !i_flush & !full.
- On push, mem[wr_ptr] ← i_data and wr_ptr advances. On pop, rd_ptr advances.
- Pointers wrap from DEPTH-1 to 0 (explicit compare, not modulo-2^n).
- count' = count + push − pop. Push and pop together leave count unchanged, including when full in mode 0.
- With DEPTH=1 and RTR_MODE=0, behaviour is cycle-identical to the legacy single-entry pipe stage.
- Flush:
  - Next cycle count=0 and wr_ptr=rd_ptr=0.
  - o_rtr=0 during the flush cycle, so any upstream request is not accepted.
  - A downstream pop in the flush cycle is still a legal handshake. The popped entry is consumed; the remaining entries are discarded.
- Reset (asynchronous, any time, including mid-transfer):
  - count=0, pointers=0, all mem entries=0.
  - Outputs: o_rts=0, o_data=0, o_count=0, o_empty=1, o_full=0.
  - o_rtr = 1 (given i_flush=0, which it is not forced to be).
  - In-flight data is lost. No handshake completes in a cycle where reset is asserted.
- Upstream must hold i_rts and i_data stable until accepted. Downstream sees the same guarantee from this block.

## Timing
- Latency: data pushed in cycle N is visible on o_rts/o_data at cycle N+1 if the FIFO was empty. Otherwise it is visible after all older entries have been popped.
- Throughput: 1 transfer/cycle sustained for DEPTH≥1 in mode 0, and for DEPTH≥2 in mode 1. Mode 1 with DEPTH=1 gives 50%.
- o_count, o_full and o_empty are registered-state decodes, valid the cycle after the handshake.
- Only combinational paths:
  - i_rtr→o_rtr (mode 0 only).
  - i_flush→o_rtr.
- Simulation-only checks under SIM:
  - RTS must not be dropped without RTR (unless NORTS_DROPPED).
  - Data must be stable while pending.
  - No push when full without a pop, and no pop when empty.

## Structure
- Package tt_rts_rtr_pkg holds:
  - localparams RTR_MODE_PASS=0 and RTR_MODE_REG=1.
  - a count-width function cnt_w(depth) = $clog2(depth+1).
- Sub-module tt_rts_rtr_fifo_ptr (parameter DEPTH) holds the pointer/count controller. It takes push, pop and flush and produces wr_ptr, rd_ptr, count, full and empty. Storage and handshake logic stay in the top.

## Test plan
- Reset mid-stream:
  - Stimulus: DEPTH=4, RTR_MODE=0, 3 entries held, assert i_reset_n=0 between clock edges.
  - Response: o_rts, o_count and o_data go to 0 immediately; o_rtr=1.
- Fill and drain:
  - Stimulus: DEPTH=3, RTR_MODE=1, i_rtr=0, push 0xA, 0xB, 0xC.
  - Response: o_full=1 and o_rtr=0 after the third push. Then with i_rtr=1 the bench pops A, B, C on consecutive cycles and o_empty=1.
- Full pass-through:
  - Stimulus: DEPTH=2, RTR_MODE=0, full, i_rts=i_rtr=1 for 10 cycles.
  - Response: o_rtr=1 every cycle, count stays 2, data in order.
- Non-power-of-two wrap:
  - Stimulus: DEPTH=5, stream 20 values with random i_rtr stalls.
  - Response: output sequence equals input sequence and o_count never exceeds 5.
- Flush with pending pop:
  - Stimulus: DEPTH=4, 3 entries, i_flush=1, i_rtr=1, i_rts=1.
  - Response: o_rtr=0 that cycle, head popped, next cycle o_count=0, and the upstream item is presented again later.
- Legacy equivalence:
  - Stimulus: DEPTH=1, RTR_MODE=0, random stimulus.
  - Response: o_rts, o_rtr and o_data match a legacy single-entry pipe stage cycle-for-cycle.
